// File: rtl/calc_pkg.sv
// Shared key codes, state and operator encodings for the keypad calculator sequencer.
package calc_pkg;

    localparam int unsigned KEY_ADD = 'h10;
    localparam int unsigned KEY_SUB = 'h11;
    localparam int unsigned KEY_AND = 'h12;
    localparam int unsigned KEY_EXE = 'h13;
    localparam int unsigned KEY_OR  = 'h14;
    localparam int unsigned KEY_BSP = 'h15;
    localparam int unsigned KEY_CE  = 'h16;
    localparam int unsigned KEY_CLR = 'h17;

    typedef enum logic [1:0] {
        ST_W1  = 2'd0,
        ST_W2  = 2'd1,
        ST_WOP = 2'd2,
        ST_GOP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational calculator ALU: ADD/SUB with carry/borrow, bitwise AND/OR.
module calc_alu
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] y,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // Extended-width add/sub so bit DATA_W holds carry-out / borrow.
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        y     = '0;
        carry = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                y     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_SUB: begin
                y     = diff[DATA_W-1:0];
                carry = diff[DATA_W];
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            default: ;
        endcase
    end

endmodule

// File: rtl/calc_entry_fsm.sv
// Keypad calculator entry sequencer: operand A/B entry, operator select, registered result.
// Optional: define CALC_RESULT_CHAIN_EN so EXE in GOP feeds the result back as operand A.
module calc_entry_fsm
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NDIG   = DATA_W / 4,
    parameter int unsigned KEY_W  = 5
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      key_valid,
    input  logic [KEY_W-1:0]          key_code,
    output logic [1:0]                estado_alu,
    output logic [DATA_W-1:0]         op_a,
    output logic [DATA_W-1:0]         op_b,
    output logic [1:0]                op_sel,
    output logic [DATA_W-1:0]         disp_val,
    output logic [$clog2(NDIG+1)-1:0] digit_cnt,
    output logic [DATA_W-1:0]         result,
    output logic                      result_valid,
    output logic                      carry
);

    localparam int unsigned CNT_W = $clog2(NDIG + 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    op_e                 op_sel_q, op_sel_d;
    logic [CNT_W-1:0]    cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]    cnt_b_q, cnt_b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                carry_q, carry_d;
    logic                result_valid_q, result_valid_d;
    logic [DATA_W-1:0]   disp_val_q, disp_val_d;
    logic [CNT_W-1:0]    digit_cnt_q, digit_cnt_d;

    logic                is_digit;
    logic [3:0]          digit;
    logic                k_add, k_sub, k_and, k_or, k_exe, k_bsp, k_ce, k_clr;
    logic                clr_all;
    logic [DATA_W-1:0]   alu_y;
    logic                alu_carry;

    calc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a     (op_a_q),
        .b     (op_b_q),
        .op    (op_sel_q),
        .y     (alu_y),
        .carry (alu_carry)
    );

    // Key decode; upper code bits zero means a hex digit.
    always_comb begin
        is_digit = (key_code[KEY_W-1:4] == '0);
        digit    = key_code[3:0];
        k_add    = (key_code == KEY_W'(KEY_ADD));
        k_sub    = (key_code == KEY_W'(KEY_SUB));
        k_and    = (key_code == KEY_W'(KEY_AND));
        k_or     = (key_code == KEY_W'(KEY_OR));
        k_exe    = (key_code == KEY_W'(KEY_EXE));
        k_bsp    = (key_code == KEY_W'(KEY_BSP));
        k_ce     = (key_code == KEY_W'(KEY_CE));
        k_clr    = (key_code == KEY_W'(KEY_CLR));
    end

    // Next-state and datapath updates; only acts on a valid key.
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_sel_d = op_sel_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        result_d = result_q;
        carry_d  = carry_q;
        clr_all  = 1'b0;

        if (key_valid) begin
            case (state_q)
                ST_W1: begin
                    if (is_digit) begin
                        if (cnt_a_q < CNT_W'(NDIG)) begin
                            op_a_d  = {op_a_q[DATA_W-5:0], digit};
                            cnt_a_d = cnt_a_q + CNT_W'(1);
                        end
                    end else if (k_bsp) begin
                        if (cnt_a_q != '0) begin
                            op_a_d  = op_a_q >> 4;
                            cnt_a_d = cnt_a_q - CNT_W'(1);
                        end
                    end else if (k_exe) begin
                        state_d = ST_W2;
                    end else if (k_ce) begin
                        op_a_d  = '0;
                        cnt_a_d = '0;
                    end else if (k_clr) begin
                        clr_all = 1'b1;
                    end
                end
                ST_W2: begin
                    if (is_digit) begin
                        if (cnt_b_q < CNT_W'(NDIG)) begin
                            op_b_d  = {op_b_q[DATA_W-5:0], digit};
                            cnt_b_d = cnt_b_q + CNT_W'(1);
                        end
                    end else if (k_bsp) begin
                        if (cnt_b_q != '0) begin
                            op_b_d  = op_b_q >> 4;
                            cnt_b_d = cnt_b_q - CNT_W'(1);
                        end
                    end else if (k_exe) begin
                        state_d = ST_WOP;
                    end else if (k_ce) begin
                        state_d = ST_W1;
                        op_b_d  = '0;
                        cnt_b_d = '0;
                    end else if (k_clr) begin
                        state_d = ST_W1;
                        clr_all = 1'b1;
                    end
                end
                ST_WOP: begin
                    if (k_add) begin
                        op_sel_d = OP_ADD;
                    end else if (k_sub) begin
                        op_sel_d = OP_SUB;
                    end else if (k_and) begin
                        op_sel_d = OP_AND;
                    end else if (k_or) begin
                        op_sel_d = OP_OR;
                    end else if (k_exe) begin
                        state_d  = ST_GOP;
                        result_d = alu_y;
                        carry_d  = alu_carry;
                    end else if (k_ce) begin
                        state_d = ST_W2;
                    end else if (k_clr) begin
                        state_d = ST_W1;
                        clr_all = 1'b1;
                    end
                end
                ST_GOP: begin
                    if (k_exe) begin
`ifdef CALC_RESULT_CHAIN_EN
                        state_d = ST_W2;
                        op_a_d  = result_q;
                        cnt_a_d = CNT_W'(NDIG);
`else
                        state_d = ST_W1;
                        op_a_d  = '0;
                        cnt_a_d = '0;
`endif
                        op_b_d  = '0;
                        cnt_b_d = '0;
                    end else if (k_ce) begin
                        state_d = ST_WOP;
                    end else if (k_clr) begin
                        state_d = ST_W1;
                        clr_all = 1'b1;
                    end
                end
                default: state_d = ST_W1;
            endcase
        end

        if (clr_all) begin
            op_a_d   = '0;
            op_b_d   = '0;
            cnt_a_d  = '0;
            cnt_b_d  = '0;
            result_d = '0;
            carry_d  = 1'b0;
            op_sel_d = OP_ADD;
        end

        // Display-side outputs are registered from next-state values to stay aligned.
        result_valid_d = (state_d == ST_GOP);
        digit_cnt_d    = (state_d == ST_W1) ? cnt_a_d : cnt_b_d;
        case (state_d)
            ST_W1:   disp_val_d = op_a_d;
            ST_GOP:  disp_val_d = result_d;
            default: disp_val_d = op_b_d;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q        <= ST_W1;
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_sel_q       <= OP_ADD;
            cnt_a_q        <= '0;
            cnt_b_q        <= '0;
            result_q       <= '0;
            carry_q        <= 1'b0;
            result_valid_q <= 1'b0;
            disp_val_q     <= '0;
            digit_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            op_sel_q       <= op_sel_d;
            cnt_a_q        <= cnt_a_d;
            cnt_b_q        <= cnt_b_d;
            result_q       <= result_d;
            carry_q        <= carry_d;
            result_valid_q <= result_valid_d;
            disp_val_q     <= disp_val_d;
            digit_cnt_q    <= digit_cnt_d;
        end
    end

    assign estado_alu   = state_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign op_sel       = op_sel_q;
    assign disp_val     = disp_val_q;
    assign digit_cnt    = digit_cnt_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign carry        = carry_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed self-checking bench for calc_entry_fsm (default and CALC_RESULT_CHAIN_EN builds).
module tb_calc_entry_fsm;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NDIG   = 4;
    localparam int unsigned KEY_W  = 5;

    localparam logic [4:0] K_ADD = 5'h10;
    localparam logic [4:0] K_SUB = 5'h11;
    localparam logic [4:0] K_AND = 5'h12;
    localparam logic [4:0] K_EXE = 5'h13;
    localparam logic [4:0] K_OR  = 5'h14;
    localparam logic [4:0] K_BSP = 5'h15;
    localparam logic [4:0] K_CE  = 5'h16;
    localparam logic [4:0] K_CLR = 5'h17;

    logic              clk_in = 1'b0;
    logic              reset;
    logic              key_valid;
    logic [KEY_W-1:0]  key_code;
    logic [1:0]        estado_alu;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [1:0]        op_sel;
    logic [DATA_W-1:0] disp_val;
    logic [2:0]        digit_cnt;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              carry;

    int errors = 0;
    int checks = 0;

    calc_entry_fsm #(
        .DATA_W (DATA_W),
        .NDIG   (NDIG),
        .KEY_W  (KEY_W)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .estado_alu   (estado_alu),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_sel       (op_sel),
        .disp_val     (disp_val),
        .digit_cnt    (digit_cnt),
        .result       (result),
        .result_valid (result_valid),
        .carry        (carry)
    );

    always #5 clk_in = ~clk_in;

    // One key per press; returns on the falling edge after the capturing rising edge.
    task automatic press(input logic [4:0] code);
        @(negedge clk_in);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk_in);
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; key_valid = 1'b0; key_code = '0;
        #12;
        checks++; if (estado_alu !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", estado_alu); end
        checks++; if (op_a !== 16'h0 || op_b !== 16'h0 || result !== 16'h0) begin errors++;
            $display("FAIL rst_regs got a=%h b=%h r=%h exp 0", op_a, op_b, result); end
        checks++; if (op_sel !== 2'd0 || result_valid !== 1'b0 || carry !== 1'b0 || digit_cnt !== 3'd0) begin errors++;
            $display("FAIL rst_flags got sel=%0d rv=%b c=%b cnt=%0d exp 0", op_sel, result_valid, carry, digit_cnt); end
        @(negedge clk_in);
        reset = 1'b0;
    endtask

    task automatic test_add();
        press(5'h01); press(5'h02); press(5'h03); press(5'h04);
        checks++; if (disp_val !== 16'h1234 || digit_cnt !== 3'd4) begin errors++;
            $display("FAIL add_entry got disp=%h cnt=%0d exp 1234/4", disp_val, digit_cnt); end
        press(K_EXE); press(5'h05); press(K_EXE); press(K_ADD);
        checks++; if (estado_alu !== 2'd2 || result_valid !== 1'b0) begin errors++;
            $display("FAIL add_wop got st=%0d rv=%b exp 2/0", estado_alu, result_valid); end
        press(K_EXE);
        checks++; if (result !== 16'h1239 || carry !== 1'b0 || result_valid !== 1'b1) begin errors++;
            $display("FAIL add_result got r=%h c=%b rv=%b exp 1239/0/1", result, carry, result_valid); end
        checks++; if (estado_alu !== 2'd3 || disp_val !== 16'h1239) begin errors++;
            $display("FAIL add_gop got st=%0d disp=%h exp 3/1239", estado_alu, disp_val); end
        press(K_EXE);
`ifdef CALC_RESULT_CHAIN_EN
        checks++; if (estado_alu !== 2'd1 || op_a !== 16'h1239 || op_b !== 16'h0 || digit_cnt !== 3'd0) begin errors++;
            $display("FAIL add_chain got st=%0d a=%h b=%h cnt=%0d exp 1/1239/0/0", estado_alu, op_a, op_b, digit_cnt); end
`else
        checks++; if (estado_alu !== 2'd0 || op_a !== 16'h0 || op_b !== 16'h0 || digit_cnt !== 3'd0) begin errors++;
            $display("FAIL add_exe_w1 got st=%0d a=%h b=%h cnt=%0d exp 0/0/0/0", estado_alu, op_a, op_b, digit_cnt); end
`endif
        checks++; if (result !== 16'h1239 || result_valid !== 1'b0) begin errors++;
            $display("FAIL add_hold got r=%h rv=%b exp 1239/0", result, result_valid); end
    endtask

    task automatic test_digits();
        press(K_CLR);
        press(5'h01); press(5'h02); press(5'h03); press(5'h04); press(5'h05);
        checks++; if (op_a !== 16'h1234 || digit_cnt !== 3'd4) begin errors++;
            $display("FAIL dig_saturate got a=%h cnt=%0d exp 1234/4", op_a, digit_cnt); end
        press(K_BSP);
        checks++; if (op_a !== 16'h0123 || digit_cnt !== 3'd3) begin errors++;
            $display("FAIL dig_bsp got a=%h cnt=%0d exp 0123/3", op_a, digit_cnt); end
        press(K_CE); press(K_BSP);
        checks++; if (op_a !== 16'h0 || digit_cnt !== 3'd0 || estado_alu !== 2'd0) begin errors++;
            $display("FAIL dig_bsp_zero got a=%h cnt=%0d st=%0d exp 0/0/0", op_a, digit_cnt, estado_alu); end
    endtask

    task automatic test_sub();
        press(K_CLR);
        press(5'h01); press(K_EXE); press(5'h02); press(K_EXE); press(K_SUB); press(K_EXE);
        checks++; if (result !== 16'hFFFF || carry !== 1'b1 || op_sel !== 2'd1) begin errors++;
            $display("FAIL sub_borrow got r=%h c=%b sel=%0d exp FFFF/1/1", result, carry, op_sel); end
        press(K_CE);
        checks++; if (estado_alu !== 2'd2 || result_valid !== 1'b0) begin errors++;
            $display("FAIL sub_ce got st=%0d rv=%b exp 2/0", estado_alu, result_valid); end
        press(K_AND); press(K_EXE);
        checks++; if (result !== 16'h0 || carry !== 1'b0 || op_sel !== 2'd2 || result_valid !== 1'b1) begin errors++;
            $display("FAIL and_result got r=%h c=%b sel=%0d rv=%b exp 0/0/2/1", result, carry, op_sel, result_valid); end
    endtask

    task automatic test_overflow();
        press(K_CLR);
        press(5'h0F); press(5'h0F); press(5'h0F); press(5'h0F); press(K_EXE);
        press(5'h01); press(K_EXE); press(K_ADD); press(K_EXE);
        checks++; if (result !== 16'h0 || carry !== 1'b1 || result_valid !== 1'b1) begin errors++;
            $display("FAIL ovf_add got r=%h c=%b rv=%b exp 0/1/1", result, carry, result_valid); end
        press(K_EXE);
`ifdef CALC_RESULT_CHAIN_EN
        checks++; if (estado_alu !== 2'd1 || op_a !== 16'h0 || digit_cnt !== 3'd0) begin errors++;
            $display("FAIL ovf_chain got st=%0d a=%h cnt=%0d exp 1/0/0", estado_alu, op_a, digit_cnt); end
`else
        checks++; if (estado_alu !== 2'd0 || op_a !== 16'h0 || digit_cnt !== 3'd0) begin errors++;
            $display("FAIL ovf_exe got st=%0d a=%h cnt=%0d exp 0/0/0", estado_alu, op_a, digit_cnt); end
`endif
    endtask

    task automatic test_ignored();
        press(K_CLR);
        press(K_ADD); press(5'h1F);
        checks++; if (estado_alu !== 2'd0 || op_sel !== 2'd0 || op_a !== 16'h0) begin errors++;
            $display("FAIL ign_w1 got st=%0d sel=%0d a=%h exp 0/0/0", estado_alu, op_sel, op_a); end
        press(5'h07); press(K_EXE); press(5'h08); press(K_EXE); press(K_OR);
        checks++; if (estado_alu !== 2'd2 || op_sel !== 2'd3 || disp_val !== 16'h0008) begin errors++;
            $display("FAIL ign_wop got st=%0d sel=%0d disp=%h exp 2/3/0008", estado_alu, op_sel, disp_val); end
        @(negedge clk_in);
        key_code = K_EXE;
        repeat (10) @(negedge clk_in);
        checks++; if (estado_alu !== 2'd2 || result_valid !== 1'b0) begin errors++;
            $display("FAIL ign_novalid got st=%0d rv=%b exp 2/0", estado_alu, result_valid); end
        press(K_CLR);
        checks++; if (estado_alu !== 2'd0 || op_a !== 16'h0 || op_b !== 16'h0 || op_sel !== 2'd0 || digit_cnt !== 3'd0) begin errors++;
            $display("FAIL clr_wop got st=%0d a=%h b=%h sel=%0d cnt=%0d exp all 0", estado_alu, op_a, op_b, op_sel, digit_cnt); end
    endtask

    task automatic test_ce_w2();
        press(K_CLR);
        press(5'h03); press(K_EXE); press(5'h04); press(K_CE);
        checks++; if (estado_alu !== 2'd0 || op_a !== 16'h0003 || op_b !== 16'h0 || digit_cnt !== 3'd1) begin errors++;
            $display("FAIL ce_w2 got st=%0d a=%h b=%h cnt=%0d exp 0/0003/0/1", estado_alu, op_a, op_b, digit_cnt); end
    endtask

    task automatic test_reset_mid();
        press(K_CLR);
        press(5'h09); press(K_EXE); press(5'h06); press(K_EXE); press(K_OR); press(K_EXE);
        checks++; if (result !== 16'h000F || carry !== 1'b0) begin errors++;
            $display("FAIL or_result got r=%h c=%b exp 000F/0", result, carry); end
        press(K_CE); press(K_CE);
        checks++; if (estado_alu !== 2'd1 || op_b !== 16'h0006) begin errors++;
            $display("FAIL pre_reset got st=%0d b=%h exp 1/0006", estado_alu, op_b); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (estado_alu !== 2'd0 || op_a !== 16'h0 || op_b !== 16'h0 || result !== 16'h0) begin errors++;
            $display("FAIL async_rst got st=%0d a=%h b=%h r=%h exp all 0", estado_alu, op_a, op_b, result); end
        checks++; if (op_sel !== 2'd0 || result_valid !== 1'b0) begin errors++;
            $display("FAIL async_rst_flags got sel=%0d rv=%b exp 0/0", op_sel, result_valid); end
        @(negedge clk_in);
        reset = 1'b0;
        press(5'h0A);
        checks++; if (op_a !== 16'h000A || digit_cnt !== 3'd1) begin errors++;
            $display("FAIL post_rst got a=%h cnt=%0d exp 000A/1", op_a, digit_cnt); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_digits();
        test_sub();
        test_overflow();
        test_ignored();
        test_ce_w2();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
Parametrised keypad-driven calculator sequencer with a built-in datapath. Takes debounced single-cycle key events from the keypad decoder and handles the full entry sequence: operand A entry, operand B entry, operator selection, and result display. It stores both operands, the selected operator, and a registered result. Its outputs drive the VGA display formatter, which shows the value being edited, the current state and the result.

Parameters:
DATA_W, 16, operand/result width in bits; must be a multiple of 4, minimum 8.
NDIG, DATA_W/4, maximum hex digits accepted per operand; 1 <= NDIG <= DATA_W/4.
KEY_W, 5, key code width.

Ports:
clk_in  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
key_valid  in  1  one-cycle strobe; key_code is sampled only when this is 1.
key_code  in  KEY_W  key code (see Behaviour).
estado_alu  out  2  current state: 0=W1, 1=W2, 2=WOP, 3=GOP.
op_a  out  DATA_W  operand A register.
op_b  out  DATA_W  operand B register.
op_sel  out  2  operator: 0=ADD, 1=SUB, 2=AND, 3=OR.
disp_val  out  DATA_W  value to display: op_a in W1, op_b in W2/WOP, result in GOP.
digit_cnt  out  $clog2(NDIG+1)  digits entered in the operand being edited.
result  out  DATA_W  registered result.
result_valid  out  1  1 only in GOP.
carry  out  1  ADD carry-out or SUB borrow; 0 for AND/OR.

Behaviour:
- Reset (async, takes priority over everything): state=W1; op_a, op_b, result, digit counters, carry = 0; op_sel=ADD; result_valid=0.
- Key codes: 0x00-0x0F digit; 0x10 ADD; 0x11 SUB; 0x12 AND; 0x14 OR; 0x13 EXE; 0x15 BSP; 0x16 CE; 0x17 CLR. All other codes are ignored, as are keys that are not valid in the current state.
- All updates happen on the clk_in edge where key_valid=1. Only one key is processed per cycle.
- Digit entry (W1 edits A, W2 edits B):
  - digit with count<NDIG: operand <= {operand[DATA_W-5:0], digit}; count+1.
  - digit with count==NDIG: ignored (saturate, no wrap).
  - BSP with count>0: operand >>= 4; count-1.
  - BSP with count==0: no effect.
- Separate counters cnt_a and cnt_b; digit_cnt shows the counter for the active operand.
- W1:
  - EXE -> W2.
  - CE: clear A and cnt_a, stay in W1.
  - CLR: stay in W1 and clear everything.
- W2:
  - EXE -> WOP.
  - CE -> W1; clear B and cnt_b; A is retained.
  - CLR -> W1 and clear everything.
- WOP:
  - ADD/SUB/AND/OR: update op_sel, stay in WOP.
  - EXE -> GOP. On the same edge: result <= f(op_a, op_b, op_sel) and carry is updated. Latency from EXE to result_valid is 1 cycle.
  - CE -> W2 with B retained.
  - CLR -> W1.
- GOP:
  - EXE -> W1; clear A, B and the counters; result is held but result_valid drops.
  - CE -> WOP; result_valid=0.
  - CLR -> W1 and clear everything.
- Arithmetic is modulo 2^DATA_W.
  - ADD: carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - SUB: A-B; carry=1 when A<B (unsigned).
- "Clear everything": op_a, op_b, cnt_a, cnt_b, result and carry = 0; op_sel=ADD.
- Reset asserted mid-sequence aborts immediately. There is no partial state retention.

Optional Feature:
Macro CALC_RESULT_CHAIN_EN.
- Defined: EXE in GOP -> W2 with op_a <= result, cnt_a <= NDIG, B cleared. This allows chained operations.
- Undefined: EXE in GOP -> W1 as specified above.

Decomposition:
- Package calc_pkg holds:
  - key-code localparams (KEY_ADD..KEY_CLR);
  - state enum typedef (W1, W2, WOP, GOP, 2-bit);
  - operator enum typedef (2-bit).
- Sub-module calc_alu: combinational, parametrised by DATA_W; inputs a, b, op; outputs y, carry. Instantiated once and registered in calc_entry_fsm.

Test Plan:
- Reset pulse mid-W2 -> estado_alu=0, op_a=op_b=result=0, op_sel=0, result_valid=0, asynchronously.
- Keys 1,2,3,4,EXE,5,EXE,ADD,EXE -> result=0x1239, carry=0, result_valid=1 one cycle after the last EXE.
- Keys 1,2,3,4,5 in W1 -> op_a=0x1234, digit_cnt=4. Then BSP -> op_a=0x0123, digit_cnt=3.
- A=0x0001, B=0x0002, SUB, EXE -> result=0xFFFF, carry=1. Then CE -> WOP with result_valid=0; AND, EXE -> result=0x0000, carry=0.
- A=0xFFFF, B=0x0001, ADD -> result=0x0000, carry=1. Then EXE -> W1, op_a=0 (macro undefined); with CALC_RESULT_CHAIN_EN -> W2, op_a=0x0000, digit_cnt=0 for B.
- key_code=EXE held with key_valid=0 for 10 cycles -> no state change; CLR in WOP -> W1 with all cleared.
